// File: rtl/display_shifter.sv
// display_shifter: hex word rotated on right edges inside a toggle window,
// shown on a scanned active-low seven-segment display.
module display_shifter #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    toggle,
  input  logic                    right,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        shift_count,
  output logic [4*NUM_DIGITS-1:0] buffer_q,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]    IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]          buffer_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  right_dly_q, toggle_dly_q;
  logic                  right_rise, toggle_rise, toggle_fall;

  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            digit;

  assign right_rise  = right & ~right_dly_q;
  assign toggle_rise = toggle & ~toggle_dly_q;
  assign toggle_fall = ~toggle & toggle_dly_q;

  assign busy        = (state_q == ACTIVE);
  assign done        = done_q;
  assign shift_count = cnt_q;
  assign an          = an_q;
  assign seg         = seg_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // window FSM: load while idle, rotate right on edges while active
  always_comb begin
    state_d  = state_q;
    buffer_d = buffer_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          buffer_d = load_data;
          cnt_d    = '0;
        end
        if (toggle_rise) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (right_rise) begin
          buffer_d = {buffer_q[3:0], buffer_q[W-1:4]};
          cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
        if (toggle_fall) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // digit scan: hold each digit SCAN_DIV cycles, decode the lit one
  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    digit = buffer_q[4*idx_q +: 4];
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = hex7(digit);
  end

  // state, data, edge-detect and display registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      buffer_q     <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      right_dly_q  <= 1'b1;
      toggle_dly_q <= 1'b0;
      scan_q       <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
    end else begin
      state_q      <= state_d;
      buffer_q     <= buffer_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      right_dly_q  <= right;
      toggle_dly_q <= toggle;
      scan_q       <= scan_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

endmodule

// File: tb/tb_display_shifter.sv
// tb_display_shifter: scoreboard bench for display_shifter
// (8 digits, 4-cycle scan period).
module tb_display_shifter;

  logic        clk = 1'b0;
  logic        rstb, load, toggle, right;
  logic [31:0] load_data, buffer_q;
  logic        busy, done;
  logic [2:0]  shift_count;
  logic [7:0]  an;
  logic [6:0]  seg;

  int          n_chk = 0;
  int          n_fail = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] mdl;
  logic [2:0]  mcnt;

  display_shifter #(
    .NUM_DIGITS(8),
    .SCAN_DIV  (4),
    .CNT_W     (3)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .load       (load),
    .load_data  (load_data),
    .toggle     (toggle),
    .right      (right),
    .busy       (busy),
    .done       (done),
    .shift_count(shift_count),
    .buffer_q   (buffer_q),
    .an         (an),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop(input logic [63:0] got);
    string       t;
    logic [63:0] e;
    check("sb_depth", 64'(exp_q.size() > 0), 64'd1);
    if (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rot(input logic [31:0] x);
    return {x[3:0], x[31:4]};
  endfunction

  task automatic shift_pulse(input string tag);
    right = 1'b1;
    mdl   = rot(mdl);
    mcnt  = mcnt + 3'd1;
    push({tag, "_buf"}, 64'(mdl));
    push({tag, "_cnt"}, 64'(mcnt));
    tick(1);
    right = 1'b0;
    pop(64'(buffer_q));
    pop(64'(shift_count));
  endtask

  task automatic do_load(input logic [31:0] d);
    load      = 1'b1;
    load_data = d;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] prev, e_an;
    bit         found;

    rstb = 1'b0; load = 1'b0; toggle = 1'b0; right = 1'b0;
    load_data = '0;
    mdl = '0; mcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_buf", 64'd0);  pop(64'(buffer_q));
    push("rst_cnt", 64'd0);  pop(64'(shift_count));
    push("rst_busy", 64'd0); pop(64'(busy));
    push("rst_done", 64'd0); pop(64'(done));
    push("rst_an", 64'hFF);  pop(64'(an));
    push("rst_seg", 64'h7F); pop(64'(seg));
    #3 rstb = 1'b1;
    tick(2);

    // basic window with 4 spaced shifts
    do_load(32'h12345678);
    mdl = 32'h12345678; mcnt = 3'd0;
    push("ld_buf", 64'(mdl)); pop(64'(buffer_q));
    push("ld_cnt", 64'd0);    pop(64'(shift_count));
    toggle = 1'b1;
    push("busy_pre", 64'd0);  pop(64'(busy));
    tick(1);
    push("busy_rise", 64'd1); pop(64'(busy));
    for (int i = 0; i < 4; i++) begin
      shift_pulse($sformatf("w1_s%0d", i));
      tick(9);
    end
    push("w1_final", 64'h56781234); pop(64'(buffer_q));
    toggle = 1'b0;
    tick(1);
    push("w1_busy_fall", 64'd0); pop(64'(busy));
    push("w1_done", 64'd1);      pop(64'(done));
    tick(1);
    push("w1_done_off", 64'd0);  pop(64'(done));

    // held right level: one shift only, none on re-opened window
    toggle = 1'b1;
    tick(1);
    shift_pulse("hold");
    right = 1'b1;
    tick(49);
    push("hold_buf", 64'(mdl));   pop(64'(buffer_q));
    toggle = 1'b0;
    tick(5);
    toggle = 1'b1;
    tick(3);
    push("reopen_busy", 64'd1);   pop(64'(busy));
    push("reopen_buf", 64'(mdl)); pop(64'(buffer_q));
    push("reopen_cnt", 64'd5);    pop(64'(shift_count));
    toggle = 1'b0;
    tick(2);
    right = 1'b0;
    tick(2);

    // full rotation returns to the loaded word
    do_load(32'h12345678);
    mdl = 32'h12345678; mcnt = 3'd0;
    toggle = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) begin
      shift_pulse($sformatf("rot_s%0d", i));
      tick(1);
    end
    push("rot_full", 64'h12345678); pop(64'(buffer_q));
    push("rot_cnt0", 64'd0);        pop(64'(shift_count));

    // load ignored while active, taken when idle
    do_load(32'hDEADBEEF);
    push("ld_act_buf", 64'h12345678); pop(64'(buffer_q));
    push("ld_act_cnt", 64'd0);        pop(64'(shift_count));
    toggle = 1'b0;
    tick(2);
    do_load(32'hDEADBEEF);
    mdl = 32'hDEADBEEF; mcnt = 3'd0;
    push("ld_idle_buf", 64'hDEADBEEF); pop(64'(buffer_q));
    push("ld_idle_cnt", 64'd0);        pop(64'(shift_count));

    // shift and window close on the same edge
    toggle = 1'b1;
    tick(1);
    right  = 1'b1;
    toggle = 1'b0;
    push("co_buf", 64'hFDEADBEE); push("co_cnt", 64'd1);
    push("co_busy", 64'd0);       push("co_done", 64'd1);
    tick(1);
    pop(64'(buffer_q)); pop(64'(shift_count));
    pop(64'(busy));     pop(64'(done));
    tick(1);
    push("co_done_off", 64'd0); pop(64'(done));
    right = 1'b0;
    tick(2);

    // digit scan
    do_load(32'h0123456F);
    tick(2);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      prev = an;
      tick(1);
      if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    check("scan_sync", 64'(found), 64'd1);
    for (int k = 0; k < 9; k++) begin
      e_an = ~(8'd1 << (k % 8));
      push($sformatf("an_%0d", k), 64'(e_an));
      pop(64'(an));
      if (k % 8 == 0) begin
        push($sformatf("seg_F_%0d", k), 64'h0E); pop(64'(seg));
      end
      if (k == 6) begin
        push("seg_1", 64'h79); pop(64'(seg));
      end
      if (k == 7) begin
        push("seg_0", 64'h40); pop(64'(seg));
      end
      tick(2);
      push($sformatf("an_hold_%0d", k), 64'(e_an));
      pop(64'(an));
      tick(2);
    end

    // asynchronous reset mid-window
    toggle = 1'b1;
    tick(1);
    right = 1'b1;
    tick(1);
    #2 rstb = 1'b0;
    #1;
    push("ar_an", 64'hFF);  pop(64'(an));
    push("ar_seg", 64'h7F); pop(64'(seg));
    push("ar_busy", 64'd0); pop(64'(busy));
    push("ar_buf", 64'd0);  pop(64'(buffer_q));
    push("ar_cnt", 64'd0);  pop(64'(shift_count));
    #1 rstb = 1'b1;
    tick(4);
    push("ar_no_shift", 64'd0); pop(64'(buffer_q));
    push("ar_cnt_after", 64'd0); pop(64'(shift_count));
    right  = 1'b0;
    toggle = 1'b0;
    tick(2);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_shifter.md
Name: display_shifter

Overview:
Receiver/consumer for the display sequencer's `toggle`/`right` outputs. Holds an NUM_DIGITS-wide hex word and rotates it one digit right on each `right` rising edge while a `toggle` window is open. Drives a time-multiplexed, active-low seven-segment display (common-anode `an`, cathodes `seg`). Sits between the sequencer and the board display pins.

Parameters:
NUM_DIGITS, 8, number of displayed hex digits (>=2).
SCAN_DIV, 100000, clk cycles each digit stays lit (1 kHz/digit at 100 MHz).
CNT_W, 3, width of shift_count; must equal clog2(NUM_DIGITS).

Ports:
clk  input  1  system clock, rising edge.
rstb  input  1  asynchronous active-low reset.
load  input  1  one-cycle request: capture load_data into buffer.
load_data  input  4*NUM_DIGITS  new word; digit0 (rightmost) = bits [3:0].
toggle  input  1  window level from sequencer; high = shifting enabled.
right  input  1  shift request; level may stay high; only rising edges count.
busy  output  1  high while FSM is in ACTIVE.
done  output  1  one-cycle pulse when a window closes.
shift_count  output  CNT_W  shifts applied since last load, modulo NUM_DIGITS.
buffer_q  output  4*NUM_DIGITS  current displayed word.
an  output  NUM_DIGITS  digit enables, active-low, one-hot-low.
seg  output  7  segments active-low, seg[0]=a ... seg[6]=g.

Behaviour:
- Reset (rstb=0, async): buffer_q=0, shift_count=0, busy=0, done=0, an=all 1s, seg=7'h7F, FSM=IDLE, right_d=1, toggle_d=0, scan counters=0.
- Edge detect: right_d, toggle_d registered every clk. right_rise = right & ~right_d. toggle_rise/fall likewise. right_d resets to 1, so a `right` held high out of reset produces no shift.
- FSM states: IDLE, ACTIVE.
- IDLE: load=1 -> buffer_q<=load_data, shift_count<=0 next edge. toggle_rise -> ACTIVE; busy=1 from the next edge. right_rise ignored.
- ACTIVE: right_rise -> buffer_q <= {buffer_q[3:0], buffer_q[4*NUM_DIGITS-1:4]}, shift_count<=shift_count+1 (wraps to 0 after NUM_DIGITS-1). Visible 1 cycle after the cycle where right_rise is seen. load ignored (no capture, no side effect).
- ACTIVE: toggle_fall -> IDLE, busy<=0, done=1 for exactly one cycle.
- Simultaneous right_rise and toggle_fall in ACTIVE: shift is applied AND the window closes in the same edge.
- Simultaneous load and toggle_rise in IDLE: load captured, FSM enters ACTIVE.
- After NUM_DIGITS shifts: buffer_q equals the loaded word; shift_count=0.
- Scan: scan_cnt counts 0..SCAN_DIV-1. On terminal count, digit index advances 0..NUM_DIGITS-1 and wraps. an and seg are registered together: an[idx]=0, others 1; seg = decode(buffer_q digit idx). Decode is active-low hex 0-F: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, F=7'b0001110. A shift updates seg within 1 cycle for the currently lit digit.
- Reset mid-window: everything returns to reset values immediately. A `right` still high after release is not counted.

Test Plan:
- Load 32'h12345678 in IDLE, raise toggle, apply 4 right rising edges spaced 10 cycles apart, drop toggle -> buffer_q=32'h56781234, shift_count=4, busy rises 1 cycle after toggle and falls 1 cycle after it falls, done high exactly 1 cycle.
- Hold right=1 for 50 cycles inside the window, including a sequencer-style level that stays high after the window closes -> exactly one shift; no shift when toggle re-rises while right is still high.
- 8 right edges in one window from 32'h12345678 -> buffer_q=32'h12345678, shift_count=0.
- Pulse load=1 with 32'hDEADBEEF while ACTIVE -> buffer_q unchanged. Same load in IDLE -> buffer_q=32'hDEADBEEF, shift_count=0.
- right_rise coincident with toggle_fall -> shift applied, done pulses, busy=0 next cycle.
- SCAN_DIV=4, buffer_q=32'h0123456F -> an cycles FE, FD, FB, ... 7F, FE every 4 cycles; seg while an=FE is 7'b0001110, while an=7F is 7'b1000000. Assert rstb=0 mid-window -> an=FF, seg=7F, busy=0 asynchronously.
